mezz_config_scheduler: RTL and testbench
========================================

Name: mezz_config_scheduler

Overview:
- Parametrised successor to the single-mezzanine VIO configuration front end.
- Turns per-action start strobes, with a mezzanine select mask, into a queue of (mezzanine, action) configuration requests.
- Issues the requests one at a time to the downstream JTAG/config engine over a valid/ready handshake, waits for completion, and reports status.
- Supports NUM_MEZZ mezzanines, completion timeout and sticky error reporting.

Parameters:
- NUM_MEZZ, 18, number of mezzanine cards addressed.
- NUM_ACT, 7, number of action types (0 setup0, 1 setup1, 2 setup2, 3 control0, 4 control1, 5 asd_write, 6 asd_read).
- MEZZ_W, 5, width of mezzanine index; must satisfy 2**MEZZ_W >= NUM_MEZZ.
- ACT_W, 3, width of action index; must satisfy 2**ACT_W >= NUM_ACT.
- TIMEOUT_CYC, 65535, cycles to wait for eng_done before declaring a timeout.
- CNT_W, 16, width of the timeout counter and of the completed-request counter.

Ports:
- clk  in  1  system clock; all logic is on this clock.
- rst_n  in  1  asynchronous active-low reset.
- start_action  in  NUM_ACT  level strobes from the VIO; a rising edge requests that action.
- mezz_mask  in  NUM_MEZZ  mezzanines targeted by a start edge; sampled on the edge cycle.
- abort  in  1  single-cycle pulse; clears all pending requests.
- req_valid  out  1  a request is presented to the engine.
- req_ready  in  1  engine accepts the request.
- req_mezz  out  MEZZ_W  mezzanine index of the current request.
- req_action  out  ACT_W  action index of the current request.
- eng_done  in  1  single-cycle pulse: engine finished the accepted request.
- eng_err  in  1  qualifies eng_done: the request failed.
- busy  out  1  high when the FSM is not IDLE or any request is pending.
- pending  out  NUM_MEZZ*NUM_ACT  pending matrix; bit m*NUM_ACT+a is (mezzanine m, action a).
- err_sticky  out  1  set by eng_err or by a timeout.
- timeout_sticky  out  1  set by a timeout only.
- err_mezz  out  MEZZ_W  mezzanine index of the most recent error.
- err_action  out  ACT_W  action index of the most recent error.
- done_count  out  CNT_W  number of completed requests; wraps.
- clr_status  in  1  clears err_sticky, timeout_sticky, err_mezz, err_action and done_count.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; pending matrix 0; start_action edge registers 0.
- Edge detect:
  - A start_action bit is registered once; an edge is a 0->1 transition between the registered and current value.
  - On an edge of bit a, pending[m][a] is set for every m with mezz_mask[m]=1.
  - Several edges in one cycle are all accepted.
  - A mask of all zeros is ignored.
  - Setting an already-set bit merges with it; there is no double issue.
- Arbitration (in IDLE):
  - Choose the lowest action index with any pending bit.
  - Within that action, choose the first set mezzanine round-robin, starting after the last issued mezzanine index (rr_ptr).
  - Selection is registered into req_mezz/req_action; move to ISSUE the next cycle.
- FSM states:
  - IDLE -> ISSUE when any pending bit is set.
  - ISSUE: req_valid=1 and req_mezz/req_action are held stable until the cycle with req_ready=1. On that cycle: clear the chosen pending bit, update rr_ptr, clear the timeout counter, go to WAIT.
  - WAIT: req_valid=0; the counter increments each cycle.
    - eng_done=1: done_count+1. If eng_err=1, set err_sticky and load err_mezz/err_action. Go to IDLE.
    - Counter reaches TIMEOUT_CYC-1 without eng_done: set err_sticky and timeout_sticky, load err_mezz/err_action. Go to IDLE. done_count is not incremented.
- Issue throughput: at least 2 cycles between one eng_done and the next req_valid (IDLE plus a registered select).
- Re-arming: an edge that sets the same bit that is being cleared on the acceptance cycle leaves the bit set, so the request is re-queued.
- Abort:
  - Clears the whole pending matrix.
  - In ISSUE: drop req_valid next cycle and return to IDLE; nothing is accepted. This is the only case where req_valid falls before req_ready.
  - In WAIT: the in-flight request completes normally.
  - A start edge in the abort cycle is discarded.
- eng_done outside WAIT is ignored.
- Simultaneous clr_status and an error event: the error wins and the sticky bits are set.
- Asynchronous reset mid-operation: everything returns to reset values immediately, and req_valid drops with no handshake.

Decomposition:
- Shared package mezz_cfg_pkg:
  - action index constants ACT_SETUP0..ACT_ASD_READ;
  - NUM_ACT;
  - FSM state enum (IDLE, ISSUE, WAIT).
- One sub-module, mezz_rr_arbiter: parametrised NUM_MEZZ round-robin find-first-set with pointer input, producing a grant index and a grant-valid.

Test Plan:
- Single request: rise start_action[0] with mezz_mask=0x00005 -> req (mezz 0, act 0) then (mezz 2, act 0); each completes with eng_done; done_count=2, busy=0.
- Priority: setup1 edge with mask 0x1, then asd_write edge with mask 0x1 while the first request is in WAIT -> next issue is (mezz 0, act 1) only if still pending, then (mezz 0, act 5); with both pending, act 1 goes before act 5.
- Round-robin: pending act 3 for mezz {1,4,17}, rr_ptr=4 -> issue order 17, 1, 4.
- Timeout: hold req_ready=1 and never pulse eng_done, with TIMEOUT_CYC=16 -> return to IDLE 16 cycles after acceptance; err_sticky=1, timeout_sticky=1, err_mezz/err_action equal the request; done_count unchanged.
- Engine error: eng_done plus eng_err on (mezz 7, act 5) -> err_sticky=1, timeout_sticky=0, err_mezz=7, err_action=5. Then clr_status -> all cleared.
- Abort during ISSUE with req_ready=0 and 3 requests pending -> req_valid=0 next cycle, pending=0, busy=0; a start edge in the same cycle is discarded.

Source files
------------

// File: rtl/mezz_cfg_pkg.sv
// Shared definitions for the mezzanine configuration scheduler.
package mezz_cfg_pkg;

  localparam int NUM_ACT = 7;

  // Action indices as seen on start_action and req_action.
  localparam int ACT_SETUP0    = 0;
  localparam int ACT_SETUP1    = 1;
  localparam int ACT_SETUP2    = 2;
  localparam int ACT_CONTROL0  = 3;
  localparam int ACT_CONTROL1  = 4;
  localparam int ACT_ASD_WRITE = 5;
  localparam int ACT_ASD_READ  = 6;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_e;

endpackage

// File: rtl/mezz_rr_arbiter.sv
// Round-robin find-first-set: grants the first set request strictly after ptr,
// wrapping at NUM_MEZZ, so ptr itself is the last candidate considered.
module mezz_rr_arbiter #(
  parameter int NUM_MEZZ = 18,
  parameter int MEZZ_W   = 5
) (
  input  logic [NUM_MEZZ-1:0] req,
  input  logic [MEZZ_W-1:0]   ptr,
  output logic [MEZZ_W-1:0]   grant,
  output logic                grant_valid
);

  logic [MEZZ_W:0] idx;

  // Walk the candidates in rotated order and keep the first hit.
  // NOTE: every output and temporary gets a value before the loop, so no path leaves one unassigned (no latch).
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int i = 1; i <= NUM_MEZZ; i++) begin
      idx = {1'b0, ptr} + (MEZZ_W+1)'(i);
      if (idx >= (MEZZ_W+1)'(NUM_MEZZ)) idx = idx - (MEZZ_W+1)'(NUM_MEZZ);
      if (!grant_valid && req[idx[MEZZ_W-1:0]]) begin
        grant_valid = 1'b1;
        grant       = idx[MEZZ_W-1:0];
      end
    end
  end

endmodule

// File: rtl/mezz_config_scheduler.sv
// Queues (mezzanine, action) configuration requests raised by VIO start edges
// and issues them one at a time to the config engine, tracking completion,
// timeout and sticky error status.
module mezz_config_scheduler #(
  parameter int NUM_MEZZ    = 18,
  parameter int NUM_ACT     = mezz_cfg_pkg::NUM_ACT,
  parameter int MEZZ_W      = 5,
  parameter int ACT_W       = 3,
  parameter int TIMEOUT_CYC = 65535,
  parameter int CNT_W       = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_ACT-1:0]           start_action,
  input  logic [NUM_MEZZ-1:0]          mezz_mask,
  input  logic                         abort,
  output logic                         req_valid,
  input  logic                         req_ready,
  output logic [MEZZ_W-1:0]            req_mezz,
  output logic [ACT_W-1:0]             req_action,
  input  logic                         eng_done,
  input  logic                         eng_err,
  output logic                         busy,
  output logic [NUM_MEZZ*NUM_ACT-1:0]  pending,
  output logic                         err_sticky,
  output logic                         timeout_sticky,
  output logic [MEZZ_W-1:0]            err_mezz,
  output logic [ACT_W-1:0]             err_action,
  output logic [CNT_W-1:0]             done_count,
  input  logic                         clr_status
);

  import mezz_cfg_pkg::*;

  state_e                            state_q, state_d;
  logic [NUM_ACT-1:0]                start_q, start_edge;
  logic [NUM_MEZZ-1:0][NUM_ACT-1:0]  pend_q, pend_set, pend_clr;
  logic [NUM_ACT-1:0]                act_any;
  logic [ACT_W-1:0]                  sel_act;
  logic [NUM_MEZZ-1:0]               sel_col;
  logic [MEZZ_W-1:0]                 rr_ptr, grant;
  logic                              grant_valid;
  logic [CNT_W-1:0]                  tmo_cnt;
  logic                              load_sel, accept, finish, timeout;

  // Register the VIO strobes so a rising edge can be seen.
  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) start_q <= '0;
    else        start_q <= start_action;
  end

  // Lowest pending action wins; its mezzanine column feeds the round-robin arbiter.
  always_comb begin
    act_any = '0;
    sel_act = '0;
    sel_col = '0;
    for (int a = 0; a < NUM_ACT; a++)
      for (int m = 0; m < NUM_MEZZ; m++)
        act_any[a] = act_any[a] | pend_q[m][a];
    for (int a = NUM_ACT - 1; a >= 0; a--)
      if (act_any[a]) sel_act = ACT_W'(a);
    for (int m = 0; m < NUM_MEZZ; m++)
      sel_col[m] = pend_q[m][sel_act];
  end

  mezz_rr_arbiter #(
    .NUM_MEZZ (NUM_MEZZ),
    .MEZZ_W   (MEZZ_W)
  ) u_arb (
    .req         (sel_col),
    .ptr         (rr_ptr),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  // Set bits from start edges under the mask; clear the bit of an accepted request.
  always_comb begin
    start_edge = start_action & ~start_q;
    pend_set   = '0;
    pend_clr   = '0;
    for (int m = 0; m < NUM_MEZZ; m++)
      for (int a = 0; a < NUM_ACT; a++)
        pend_set[m][a] = start_edge[a] & mezz_mask[m];
    if (accept) pend_clr[req_mezz][req_action] = 1'b1;
  end

  // Pending matrix: abort wipes it, otherwise a set in the clearing cycle re-arms.
  // NOTE: the matrix is plain flops, not RAM, so it takes the async reset like any other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     pend_q <= '0;
    else if (abort) pend_q <= '0;
    else            pend_q <= (pend_q & ~pend_clr) | pend_set;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state and the one-cycle event strobes it raises.
  always_comb begin
    state_d  = state_q;
    load_sel = 1'b0;
    accept   = 1'b0;
    finish   = 1'b0;
    timeout  = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_valid && !abort) begin
          load_sel = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (req_ready) begin
          accept  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (eng_done) begin
          finish  = 1'b1;
          state_d = IDLE;
        end else if (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          timeout = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request registers, round-robin pointer and completion timer.
  // rr_ptr resets to the last index so the very first search starts at mezzanine 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_mezz   <= '0;
      req_action <= '0;
      rr_ptr     <= MEZZ_W'(NUM_MEZZ - 1);
      tmo_cnt    <= '0;
    end else begin
      if (load_sel) begin
        req_mezz   <= grant;
        req_action <= sel_act;
      end
      if (accept) begin
        rr_ptr  <= req_mezz;
        tmo_cnt <= '0;
      end else if (state_q == WAIT) begin
        tmo_cnt <= tmo_cnt + CNT_W'(1);
      end
    end
  end

  // Status: clear first, then events of the same cycle take effect on top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky     <= 1'b0;
      timeout_sticky <= 1'b0;
      err_mezz       <= '0;
      err_action     <= '0;
      done_count     <= '0;
    end else begin
      if (clr_status) begin
        err_sticky     <= 1'b0;
        timeout_sticky <= 1'b0;
        err_mezz       <= '0;
        err_action     <= '0;
        done_count     <= '0;
      end
      if (finish) begin
        done_count <= clr_status ? CNT_W'(1) : done_count + CNT_W'(1);
        if (eng_err) begin
          err_sticky <= 1'b1;
          err_mezz   <= req_mezz;
          err_action <= req_action;
        end
      end
      if (timeout) begin
        err_sticky     <= 1'b1;
        timeout_sticky <= 1'b1;
        err_mezz       <= req_mezz;
        err_action     <= req_action;
      end
    end
  end

  assign req_valid = (state_q == ISSUE);
  assign busy      = (state_q != IDLE) || (|pend_q);
  assign pending   = pend_q;

endmodule

// File: tb/tb_mezz_config_scheduler.sv
// Self-checking bench: directed scenarios plus random traffic, all compared
// cycle by cycle against a behavioural model of the scheduler rules.
module tb_mezz_config_scheduler;

  localparam int NUM_MEZZ    = 18;
  localparam int NUM_ACT     = 7;
  localparam int MEZZ_W      = 5;
  localparam int ACT_W       = 3;
  localparam int TIMEOUT_CYC = 16;
  localparam int CNT_W       = 16;
  localparam int NBITS       = NUM_MEZZ * NUM_ACT;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NUM_ACT-1:0]   start_action;
  logic [NUM_MEZZ-1:0]  mezz_mask;
  logic                 abort, req_valid, req_ready, eng_done, eng_err;
  logic [MEZZ_W-1:0]    req_mezz, err_mezz;
  logic [ACT_W-1:0]     req_action, err_action;
  logic                 busy, err_sticky, timeout_sticky, clr_status;
  logic [NBITS-1:0]     pending;
  logic [CNT_W-1:0]     done_count;

  always #5 clk = ~clk;

  mezz_config_scheduler #(
    .NUM_MEZZ    (NUM_MEZZ),
    .NUM_ACT     (NUM_ACT),
    .MEZZ_W      (MEZZ_W),
    .ACT_W       (ACT_W),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .CNT_W       (CNT_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_action   (start_action),
    .mezz_mask      (mezz_mask),
    .abort          (abort),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_mezz       (req_mezz),
    .req_action     (req_action),
    .eng_done       (eng_done),
    .eng_err        (eng_err),
    .busy           (busy),
    .pending        (pending),
    .err_sticky     (err_sticky),
    .timeout_sticky (timeout_sticky),
    .err_mezz       (err_mezz),
    .err_action     (err_action),
    .done_count     (done_count),
    .clr_status     (clr_status)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit               m_pend [NUM_MEZZ][NUM_ACT];
  bit [NUM_ACT-1:0] m_prev_start;
  bit               m_offer, m_flight, m_err_st, m_tmo_st;
  int               m_req_mezz, m_req_act, m_last, m_waited;
  int               m_err_mezz, m_err_act, m_done;

  function automatic void model_reset();
    foreach (m_pend[m, a]) m_pend[m][a] = 1'b0;
    m_prev_start = '0;
    m_offer = 1'b0; m_flight = 1'b0; m_err_st = 1'b0; m_tmo_st = 1'b0;
    m_req_mezz = 0; m_req_act = 0; m_last = -1; m_waited = 0;
    m_err_mezz = 0; m_err_act = 0; m_done = 0;
  endfunction

  // One clock edge of the scheduler, from the rules rather than any encoding.
  function automatic void model_step();
    bit [NUM_ACT-1:0] rise;
    bit any_pend = 1'b0;
    bit acc = 1'b0, fin = 1'b0, tmo = 1'b0;
    int pick_a = -1, pick_m = -1;
    rise = start_action & ~m_prev_start;
    m_prev_start = start_action;
    foreach (m_pend[m, a]) if (m_pend[m][a]) any_pend = 1'b1;
    if (!m_offer && !m_flight) begin
      if (any_pend && !abort) begin
        for (int a = 0; a < NUM_ACT && pick_a < 0; a++)
          for (int m = 0; m < NUM_MEZZ; m++)
            if (m_pend[m][a]) pick_a = a;
        for (int k = 1; k <= NUM_MEZZ && pick_m < 0; k++)
          if (m_pend[(m_last + k) % NUM_MEZZ][pick_a]) pick_m = (m_last + k) % NUM_MEZZ;
        m_req_mezz = pick_m;
        m_req_act  = pick_a;
        m_offer    = 1'b1;
      end
    end else if (m_offer) begin
      if (abort) m_offer = 1'b0;
      else if (req_ready) begin
        m_offer = 1'b0; m_flight = 1'b1; acc = 1'b1;
        m_last = m_req_mezz; m_waited = 0;
      end
    end else begin
      m_waited++;
      if (eng_done) begin fin = 1'b1; m_flight = 1'b0; end
      else if (m_waited == TIMEOUT_CYC) begin tmo = 1'b1; m_flight = 1'b0; end
    end
    if (clr_status) begin
      m_err_st = 1'b0; m_tmo_st = 1'b0; m_err_mezz = 0; m_err_act = 0; m_done = 0;
    end
    if (fin) begin
      m_done = (m_done + 1) % 65536;
      if (eng_err) begin m_err_st = 1'b1; m_err_mezz = m_req_mezz; m_err_act = m_req_act; end
    end
    if (tmo) begin
      m_err_st = 1'b1; m_tmo_st = 1'b1; m_err_mezz = m_req_mezz; m_err_act = m_req_act;
    end
    if (abort) begin
      foreach (m_pend[m, a]) m_pend[m][a] = 1'b0;
    end else begin
      if (acc) m_pend[m_req_mezz][m_req_act] = 1'b0;
      foreach (m_pend[m, a]) if (rise[a] && mezz_mask[m]) m_pend[m][a] = 1'b1;
    end
  endfunction

  task automatic compare_all();
    logic [NBITS-1:0] ep;
    bit eb;
    ep = '0;
    eb = m_offer || m_flight;
    foreach (m_pend[m, a]) begin
      ep[m*NUM_ACT + a] = m_pend[m][a];
      if (m_pend[m][a]) eb = 1'b1;
    end
    check("req_valid", 128'(req_valid), 128'(m_offer));
    check("req_sel", 128'({req_mezz, req_action}), 128'({MEZZ_W'(m_req_mezz), ACT_W'(m_req_act)}));
    check("busy", 128'(busy), 128'(eb));
    check("pending", 128'(pending), 128'(ep));
    check("status", 128'({err_sticky, timeout_sticky, err_mezz, err_action}),
          128'({m_err_st, m_tmo_st, MEZZ_W'(m_err_mezz), ACT_W'(m_err_act)}));
    check("done_count", 128'(done_count), 128'(CNT_W'(m_done)));
  endtask

  // ---------------- engine + cycle driver ----------------
  // 0 random, 1 ready and done after 3 cycles, 2 ready but never done,
  // 3 like 1 with eng_err, 4 never ready.
  int eng_mode = 0;
  int cyc_no   = 0;
  int last_acc = 0;
  int issued[$];

  task automatic cycle();
    case (eng_mode)
      0: begin
        req_ready = ($urandom_range(0, 2) != 0);
        eng_done  = m_flight ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 9) == 0);
        eng_err   = ($urandom_range(0, 3) == 0);
      end
      1, 3: begin
        req_ready = 1'b1;
        eng_done  = m_flight && (m_waited + 1 == 3);
        eng_err   = (eng_mode == 3);
      end
      2: begin req_ready = 1'b1; eng_done = 1'b0; eng_err = 1'b0; end
      default: begin req_ready = 1'b0; eng_done = 1'b0; eng_err = 1'b0; end
    endcase
    if (req_valid && req_ready && !abort) begin
      issued.push_back(int'(req_mezz) * 8 + int'(req_action));
      last_acc = cyc_no + 1;
    end
    @(posedge clk);
    cyc_no++;
    model_step();
    @(negedge clk);
    compare_all();
    abort      = 1'b0;
    clr_status = 1'b0;
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    int n = 0;
    do begin
      cycle();
      n++;
    end while (busy && n < budget);
    check(tag, 128'(busy), 128'(0));
  endtask

  task automatic apply_reset();
    start_action = '0; mezz_mask = '0; abort = 1'b0; clr_status = 1'b0;
    req_ready = 1'b0; eng_done = 1'b0; eng_err = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    apply_reset();
    check("rst_valid", 128'(req_valid), 128'(0));
    check("rst_pending", 128'(pending), 128'(0));
    check("rst_status", 128'({busy, err_sticky, timeout_sticky, err_mezz, err_action, done_count}), 128'(0));

    // Single action, two mezzanines: issued in index order from reset.
    eng_mode = 1;
    mezz_mask = 18'h00005; start_action = 7'b0000001;
    run_until_idle("single_drain", 100);
    check("single_n", 128'(issued.size()), 128'(2));
    check("single_0", 128'(issued[0]), 128'(0 * 8 + 0));
    check("single_1", 128'(issued[1]), 128'(2 * 8 + 0));
    check("single_done", 128'(done_count), 128'(2));

    // Priority: setup1 re-raised with asd_write while setup1 is in flight.
    issued.delete();
    start_action = '0; cycle();
    mezz_mask = 18'h00001; start_action = 7'b0000010;
    repeat (3) cycle();
    start_action = '0; cycle();
    start_action = 7'b0100010; cycle();
    run_until_idle("prio_drain", 100);
    check("prio_n", 128'(issued.size()), 128'(3));
    check("prio_1", 128'(issued[1]), 128'(0 * 8 + 1));
    check("prio_2", 128'(issued[2]), 128'(0 * 8 + 5));

    // Round-robin: park the pointer on 4, then {1,4,17} must go 17, 1, 4.
    issued.delete();
    start_action = '0; cycle();
    mezz_mask = 18'h00010; start_action = 7'b0001000;
    run_until_idle("rr_setup", 100);
    start_action = '0; cycle();
    mezz_mask = 18'h20012; start_action = 7'b0001000;
    run_until_idle("rr_drain", 100);
    check("rr_n", 128'(issued.size()), 128'(4));
    check("rr_1", 128'(issued[1]), 128'(17 * 8 + 3));
    check("rr_2", 128'(issued[2]), 128'(1 * 8 + 3));
    check("rr_3", 128'(issued[3]), 128'(4 * 8 + 3));

    // Timeout: engine never answers.
    eng_mode = 2;
    start_action = '0; cycle();
    mezz_mask = 18'h00200; start_action = 7'b0000001;
    run_until_idle("tmo_drain", 100);
    check("tmo_latency", 128'(cyc_no - last_acc), 128'(TIMEOUT_CYC));
    check("tmo_flags", 128'({err_sticky, timeout_sticky}), 128'(2'b11));
    check("tmo_loc", 128'({err_mezz, err_action}), 128'({5'd9, 3'd0}));
    check("tmo_done", 128'(done_count), 128'(9));

    // Engine error on (7, asd_write), then clear.
    clr_status = 1'b1; start_action = '0; cycle();
    check("clr_1", 128'({err_sticky, timeout_sticky, done_count}), 128'(0));
    eng_mode = 3;
    mezz_mask = 18'h00080; start_action = 7'b0100000;
    run_until_idle("err_drain", 100);
    check("err_flags", 128'({err_sticky, timeout_sticky}), 128'(2'b10));
    check("err_loc", 128'({err_mezz, err_action}), 128'({5'd7, 3'd5}));
    check("err_done", 128'(done_count), 128'(1));
    clr_status = 1'b1; start_action = '0; cycle();
    check("clr_2", 128'({err_sticky, timeout_sticky, err_mezz, err_action, done_count}), 128'(0));

    // Abort while offering with three pending; a same-cycle edge is dropped.
    eng_mode = 4;
    mezz_mask = 18'h00007; start_action = 7'b0000100; cycle();
    for (int n = 0; n < 10 && !req_valid; n++) cycle();
    check("abort_setup", 128'(req_valid), 128'(1));
    abort = 1'b1; mezz_mask = 18'h00001; start_action = 7'b0010100; cycle();
    check("abort_state", 128'({req_valid, busy, pending}), 128'(0));
    start_action = '0; cycle();
    check("abort_quiet", 128'(busy), 128'(0));

    // Random traffic with an asynchronous reset in the middle.
    eng_mode = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0)
        start_action = start_action ^ NUM_ACT'(1 << $urandom_range(0, NUM_ACT - 1));
      case ($urandom_range(0, 7))
        0:       mezz_mask = '0;
        1:       mezz_mask = NUM_MEZZ'(1) << $urandom_range(0, NUM_MEZZ - 1);
        default: mezz_mask = NUM_MEZZ'($urandom);
      endcase
      abort      = ($urandom_range(0, 49) == 0);
      clr_status = ($urandom_range(0, 39) == 0);
      if (i == 1500) begin
        #2 rst_n = 1'b0;
        #1 check("async_rst", 128'({req_valid, busy, pending, err_sticky, timeout_sticky,
                                    err_mezz, err_action, done_count}), 128'(0));
        apply_reset();
      end
      cycle();
    end

    eng_mode = 1;
    start_action = '0; abort = 1'b0; clr_status = 1'b0;
    run_until_idle("final_drain", 4000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
